// File: rtl/eth_frame_gen_pkg.sv
// Shared constants, FSM state type and length clamp for the Ethernet frame generator.
package eth_frame_gen_pkg;

  localparam int N_SYMBOLS   = 8;
  localparam int W_SYMBOL    = 8;
  localparam int ETH_HDR_LEN = 14;
  localparam int GEN_MIN_LEN = 60;
  localparam int GEN_MAX_LEN = 1514;
  localparam int LEN_W       = 11;
  localparam int IDX_W       = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } gen_state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int min_len,
                                                 input int max_len);
    if (len < LEN_W'(min_len)) return LEN_W'(min_len);
    if (len > LEN_W'(max_len)) return LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/eth_frame_gen_if.sv
// AXI-Stream bundle between the frame generator (master) and the MAC TX input (slave).
interface eth_frame_gen_if;
  import eth_frame_gen_pkg::*;

  logic                            tvalid;
  logic [N_SYMBOLS*W_SYMBOL-1:0]   tdata;
  logic [N_SYMBOLS-1:0]            tkeep;
  logic                            tlast;
  logic                            tready;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/eth_gen_beat_builder.sv
// Combinational beat former: maps byte index b..b+N-1 onto header fields or the
// sequence-seeded payload ramp, and derives tkeep/tlast from the frame length.
module eth_gen_beat_builder
  import eth_frame_gen_pkg::*;
(
  input  logic [IDX_W-1:0]                i_b,
  input  logic [LEN_W-1:0]                i_len,
  input  logic [7:0]                      i_seq,
  input  logic [47:0]                     i_dst_mac,
  input  logic [47:0]                     i_src_mac,
  input  logic [15:0]                     i_ethertype,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]   o_tdata,
  output logic [N_SYMBOLS-1:0]            o_tkeep,
  output logic                            o_tlast
);

  logic [ETH_HDR_LEN*8-1:0] w_hdr;
  logic [LEN_W-1:0]         w_rem;

  assign w_hdr = {i_dst_mac, i_src_mac, i_ethertype};
  assign w_rem = i_len % LEN_W'(N_SYMBOLS);

  always_comb begin
    logic [IDX_W-1:0] idx;
    int               hidx;
    o_tdata = '0;
    for (int k = 0; k < N_SYMBOLS; k++) begin
      idx  = i_b + IDX_W'(k);
      hidx = 0;
      if (idx < IDX_W'(ETH_HDR_LEN)) begin
        hidx = ETH_HDR_LEN - 1 - int'(idx);
        o_tdata[k*W_SYMBOL +: W_SYMBOL] = W_SYMBOL'(w_hdr[hidx*8 +: 8]);
      end else begin
        // Payload byte i is seq + (i - 14), wrapping modulo 256.
        o_tdata[k*W_SYMBOL +: W_SYMBOL] = W_SYMBOL'(i_seq + idx[7:0] - 8'(ETH_HDR_LEN));
      end
    end
  end

  always_comb begin
    o_tlast = (i_b + IDX_W'(N_SYMBOLS)) >= IDX_W'(i_len);
    o_tkeep = '1;
    if (o_tlast && (w_rem != '0))
      o_tkeep = N_SYMBOLS'((32'd1 << w_rem) - 32'd1);
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Back-to-back Ethernet frame source (FCS excluded) with run control, IFG
// insertion and a deterministic payload ramp seeded by a per-frame sequence number.
module eth_frame_gen
  import eth_frame_gen_pkg::*;
#(
  parameter int MIN_LEN = GEN_MIN_LEN,
  parameter int MAX_LEN = GEN_MAX_LEN
) (
  input  logic                  i_tx_clk,
  input  logic                  i_tx_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [15:0]           i_n_frames,
  input  logic [LEN_W-1:0]      i_frame_len,
  input  logic [7:0]            i_ifg_cycles,
  input  logic [47:0]           i_dst_mac,
  input  logic [47:0]           i_src_mac,
  input  logic [15:0]           i_ethertype,
  eth_frame_gen_if.master       m_axis,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_frame_cnt
);

  gen_state_t                    r_state, w_next;
  logic [IDX_W-1:0]              r_b;
  logic [LEN_W-1:0]              r_len;
  logic [7:0]                    r_seq, r_ifg, r_gap_cnt;
  logic [47:0]                   r_dst, r_src;
  logic [15:0]                   r_eth, r_run_cnt;
  logic [31:0]                   r_frame_cnt;
  logic                          r_done;
  logic                          w_send, w_xfer, w_frame_end, w_run_done, w_finish, w_tlast;
  logic [N_SYMBOLS*W_SYMBOL-1:0] w_tdata;
  logic [N_SYMBOLS-1:0]          w_tkeep;

  eth_gen_beat_builder u_beat (
    .i_b         (r_b),
    .i_len       (r_len),
    .i_seq       (r_seq),
    .i_dst_mac   (r_dst),
    .i_src_mac   (r_src),
    .i_ethertype (r_eth),
    .o_tdata     (w_tdata),
    .o_tkeep     (w_tkeep),
    .o_tlast     (w_tlast)
  );

  assign w_send      = (r_state == SEND);
  assign w_xfer      = w_send && m_axis.tready;
  assign w_frame_end = w_xfer && w_tlast;
  assign w_run_done  = ((i_n_frames != 16'd0) && ((r_run_cnt + 16'd1) == i_n_frames)) || i_stop;

  always_ff @(posedge i_tx_clk or posedge i_tx_reset) begin
    if (i_tx_reset) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next = LOAD;
      LOAD: w_next = SEND;
      SEND: begin
        if (w_frame_end) begin
          if (w_run_done) begin
            w_next   = IDLE;
            w_finish = 1'b1;
          end else if (r_ifg == 8'd0) begin
            w_next = LOAD;
          end else begin
            w_next = GAP;
          end
        end
      end
      GAP: begin
        if (i_stop) begin
          w_next   = IDLE;
          w_finish = 1'b1;
        end else if (r_gap_cnt == (r_ifg - 8'd1)) begin
          w_next = LOAD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_reset) begin
    if (i_tx_reset) begin
      r_b         <= '0;
      r_seq       <= '0;
      r_gap_cnt   <= '0;
      r_run_cnt   <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if ((r_state == IDLE) && i_start) r_run_cnt <= '0;
      if (r_state == LOAD)  r_b <= '0;
      else if (w_xfer)      r_b <= r_b + IDX_W'(N_SYMBOLS);
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 8'd1 : 8'd0;
      if (w_frame_end) begin
        r_seq       <= r_seq + 8'd1;
        r_frame_cnt <= r_frame_cnt + 32'd1;
        r_run_cnt   <= r_run_cnt + 16'd1;
      end
    end
  end

  // Frame parameters are sampled only in LOAD; they need no reset since tvalid gates their use.
  always_ff @(posedge i_tx_clk) begin
    if (r_state == LOAD) begin
      r_len <= clamp_len(i_frame_len, MIN_LEN, MAX_LEN);
      r_dst <= i_dst_mac;
      r_src <= i_src_mac;
      r_eth <= i_ethertype;
      r_ifg <= i_ifg_cycles;
    end
  end

  assign m_axis.tvalid = w_send;
  assign m_axis.tdata  = w_send ? w_tdata : '0;
  assign m_axis.tkeep  = w_send ? w_tkeep : '0;
  assign m_axis.tlast  = w_send && w_tlast;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Randomized self-checking bench for eth_frame_gen against a byte-level frame model.
`timescale 1ns/1ps
module tb_eth_frame_gen;
  import eth_frame_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] n_frames = '0;
  logic [10:0] frame_len = '0;
  logic [7:0]  ifg = '0;
  logic [47:0] dst = '0;
  logic [47:0] src = '0;
  logic [15:0] eth = '0;
  logic        busy, done;
  logic [31:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_seq = 0;
  int exp_cnt = 0;

  eth_frame_gen_if axis ();

  eth_frame_gen dut (
    .i_tx_clk     (clk),
    .i_tx_reset   (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_n_frames   (n_frames),
    .i_frame_len  (frame_len),
    .i_ifg_cycles (ifg),
    .i_dst_mac    (dst),
    .i_src_mac    (src),
    .i_ethertype  (eth),
    .m_axis       (axis.master),
    .o_busy       (busy),
    .o_done       (done),
    .o_frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Byte i of a frame whose sequence number is seq.
  function automatic logic [7:0] model_byte(input int i, input int seq);
    if (i < 6)  return dst[8*(5-i) +: 8];
    if (i < 12) return src[8*(11-i) +: 8];
    if (i < 14) return eth[8*(13-i) +: 8];
    return 8'((seq + i - 14) % 256);
  endfunction

  task automatic randomize_hdr();
    dst = {16'($urandom()), 32'($urandom())};
    src = {16'($urandom()), 32'($urandom())};
    eth = 16'($urandom());
  endtask

  // stop_mode: 0 none, 1 raise i_stop on beat 2 of frame stop_frame,
  // 2 raise i_stop in the gap after frame stop_frame.
  task automatic run(input int len_req, input int nfr, input int ifg_n, input int pct,
                     input int stop_mode, input int stop_frame);
    int eff_len, beats_exp, frames, beat, lowcnt, dones, cyc, nvalid, frames_exp;
    bit gap_pending, hold;
    logic [63:0] h_data, exp_data, mask;
    logic [7:0]  h_keep, exp_keep;
    logic        h_last;
    eff_len   = (len_req < 60) ? 60 : ((len_req > 1514) ? 1514 : len_req);
    beats_exp = (eff_len + 7) / 8;
    frames = 0; beat = 0; lowcnt = 0; dones = 0; cyc = 0;
    gap_pending = 1'b0; hold = 1'b0;
    h_data = '0; h_keep = '0; h_last = 1'b0;
    randomize_hdr();
    frame_len = 11'(len_req);
    n_frames  = 16'(nfr);
    ifg       = 8'(ifg_n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (1) begin
      cyc++;
      if (cyc > 20000) begin
        checks++; errors++;
        $display("FAIL run_timeout: got busy=%0d after %0d cycles, expected idle", busy, cyc);
        break;
      end
      if (hold) begin
        chk("hold_valid", 64'(axis.tvalid), 64'd1);
        chk("hold_data",  axis.tdata, h_data);
        chk("hold_keep",  64'(axis.tkeep), 64'(h_keep));
        chk("hold_last",  64'(axis.tlast), 64'(h_last));
      end
      hold = 1'b0;
      axis.tready = ($urandom_range(99) < pct);
      if (axis.tvalid) begin
        if (gap_pending) begin
          chk("ifg_low_cycles", 64'(lowcnt), 64'(ifg_n + 1));
          gap_pending = 1'b0;
        end
        if (stop_mode == 1 && frames == stop_frame - 1 && beat == 2) stop = 1'b1;
        if (axis.tready) begin
          nvalid = eff_len - beat * 8;
          if (nvalid > 8) nvalid = 8;
          if (nvalid < 0) nvalid = 0;
          exp_data = '0; mask = '0;
          for (int k = 0; k < nvalid; k++) begin
            exp_data[8*k +: 8] = model_byte(beat * 8 + k, exp_seq);
            mask[8*k +: 8]     = 8'hFF;
          end
          exp_keep = 8'((1 << nvalid) - 1);
          chk("beat_data", axis.tdata & mask, exp_data);
          chk("beat_keep", 64'(axis.tkeep), 64'(exp_keep));
          chk("beat_last", 64'(axis.tlast), 64'(beat == beats_exp - 1));
          beat++;
          if (axis.tlast) begin
            chk("frame_beats", 64'(beat), 64'(beats_exp));
            frames++;
            exp_seq = (exp_seq + 1) % 256;
            exp_cnt++;
            beat = 0; lowcnt = 0; gap_pending = 1'b1;
          end
        end else begin
          hold = 1'b1;
          h_data = axis.tdata; h_keep = axis.tkeep; h_last = axis.tlast;
        end
      end else if (gap_pending) begin
        lowcnt++;
        if (stop_mode == 2 && frames == stop_frame && lowcnt == 3) stop = 1'b1;
      end
      if (done) dones++;
      if (!busy) break;
      @(posedge clk); #1;
    end
    stop = 1'b0;
    axis.tready = 1'b0;
    frames_exp = (nfr != 0) ? nfr : stop_frame;
    chk("run_frames",  64'(frames), 64'(frames_exp));
    chk("done_pulses", 64'(dones), 64'd1);
    chk("frame_cnt",   64'(frame_cnt), 64'(exp_cnt));
    chk("idle_valid",  64'(axis.tvalid), 64'd0);
    @(posedge clk); #1;
    chk("done_cleared", 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    axis.tready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("rst_tdata",  axis.tdata, 64'd0);
    chk("rst_tkeep",  64'(axis.tkeep), 64'd0);
    chk("rst_tlast",  64'(axis.tlast), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_cnt",    frame_cnt, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(64, 1, 0, 100, 0, 0);
    run(65, 1, 0, 100, 0, 0);
    run(20, 1, 0, 100, 0, 0);
    run(100, 3, 0, 50, 0, 0);
    run(100, 0, 5, 100, 1, 2);
    run(80, 0, 10, 70, 2, 1);
    run(64, 2, 0, 100, 0, 0);
    for (int r = 0; r < 4; r++)
      run(int'($urandom_range(2047, 1)), int'($urandom_range(3, 1)),
          int'($urandom_range(4, 0)), int'($urandom_range(100, 30)), 0, 0);

    // Asynchronous reset while beat 3 of a frame is on the bus.
    randomize_hdr();
    frame_len = 11'd64; n_frames = 16'd1; ifg = 8'd0;
    axis.tready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!axis.tvalid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(axis.tvalid), 64'd1);
    chk("pre_rst_beat3", axis.tdata[7:0], 64'(model_byte(24, exp_seq)));
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("arst_tlast",  64'(axis.tlast), 64'd0);
    chk("arst_busy",   64'(busy), 64'd0);
    chk("arst_cnt",    frame_cnt, 64'd0);
    exp_seq = 0;
    exp_cnt = 0;
    axis.tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(64, 1, 0, 100, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
